// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank.
package clk_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor, toggle or strobe output.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] divisor,
    input  logic             load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             pending
);

    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] shadow_div;
    logic             mode_r;

    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] active_n;
    logic [WIDTH-1:0] shadow_n;
    logic             clk_out_n;
    logic             tick_n;
    logic             pending_n;
    logic             mode_n;
    logic             terminal_c;

    // >= keeps the channel wrapping even if a direct load shrank the divisor below a held count
    assign terminal_c = en && (count >= active_div);

    always_comb begin
        count_n   = count;
        active_n  = active_div;
        shadow_n  = shadow_div;
        clk_out_n = clk_out;
        tick_n    = 1'b0;
        pending_n = pending;
        mode_n    = mode_r;

        if (sync) begin
            count_n   = '0;
            clk_out_n = 1'b1;
            mode_n    = mode;
            pending_n = 1'b0;
            if (load) begin
                active_n = divisor;
                shadow_n = divisor;
            end else if (pending) begin
                active_n = shadow_div;
            end
        end else begin
            if (load && (terminal_c || !en)) begin
                active_n  = divisor;
                shadow_n  = divisor;
                pending_n = 1'b0;
            end else if (load) begin
                shadow_n  = divisor;
                pending_n = 1'b1;
            end else if (terminal_c && pending) begin
                active_n  = shadow_div;
                pending_n = 1'b0;
            end

            // mode is only sampled at the wrap so the output level never glitches mid-period
            if (terminal_c) begin
                count_n   = '0;
                tick_n    = 1'b1;
                mode_n    = mode;
                clk_out_n = (mode == MODE_PULSE) ? 1'b1 : ~clk_out;
            end else if (en) begin
                count_n = count + WIDTH'(1);
                if (mode_r == MODE_PULSE) begin
                    clk_out_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            active_div <= WIDTH'(DIV_RESET);
            shadow_div <= WIDTH'(DIV_RESET);
            clk_out    <= 1'b1;
            tick       <= 1'b0;
            pending    <= 1'b0;
            mode_r     <= MODE_TOGGLE;
        end else begin
            count      <= count_n;
            active_div <= active_n;
            shadow_div <= shadow_n;
            clk_out    <= clk_out_n;
            tick       <= tick_n;
            pending    <= pending_n;
            mode_r     <= mode_n;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one input clock.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic                      CLK_IN,
    input  logic                      RESET_N,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       MODE,
    input  logic [CHANNELS*WIDTH-1:0] DIVISOR,
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic                      SYNC,
    output logic [CHANNELS-1:0]       CLK_OUT,
    output logic [CHANNELS-1:0]       TICK,
    output logic [CHANNELS*WIDTH-1:0] CLK_COUNT,
    output logic [CHANNELS-1:0]       PENDING
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_channel #(
            .WIDTH     (WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk     (CLK_IN),
            .rst_n   (RESET_N),
            .en      (EN[i]),
            .mode    (MODE[i]),
            .divisor (DIVISOR[i*WIDTH +: WIDTH]),
            .load    (LOAD[i]),
            .sync    (SYNC),
            .clk_out (CLK_OUT[i]),
            .tick    (TICK[i]),
            .count   (CLK_COUNT[i*WIDTH +: WIDTH]),
            .pending (PENDING[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: expectations queued per cycle, compared after each edge.
module tb_clk_div_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 32;

    logic            clk_in  = 1'b0;
    logic            reset_n = 1'b0;
    logic [CH-1:0]   en      = '0;
    logic [CH-1:0]   mode    = '0;
    logic [CH*W-1:0] divisor = '0;
    logic [CH-1:0]   load    = '0;
    logic            sync    = 1'b0;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH*W-1:0] clk_count;
    logic [CH-1:0]   pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ch;
        int          k;
        logic [34:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .DIV_RESET(1)) dut (
        .CLK_IN    (clk_in),
        .RESET_N   (reset_n),
        .EN        (en),
        .MODE      (mode),
        .DIVISOR   (divisor),
        .LOAD      (load),
        .SYNC      (sync),
        .CLK_OUT   (clk_out),
        .TICK      (tick),
        .CLK_COUNT (clk_count),
        .PENDING   (pending)
    );

    always #5 clk_in = ~clk_in;

    // {clk_out, tick, pending, count}
    function automatic logic [34:0] observe(int ch);
        return {clk_out[ch], tick[ch], pending[ch], clk_count[ch*W +: W]};
    endfunction

    // Expected state k edges after a phase start (count 0) with divisor d
    function automatic logic [34:0] steady(int k, int d, logic md, logic clk0, logic pend);
        int   ph;
        logic t;
        logic c;
        ph = k % (d + 1);
        t  = (ph == 0);
        c  = md ? t : (clk0 ^ (((k / (d + 1)) % 2) == 1));
        return {c, t, pend, 32'(ph)};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_sync(input logic [CH-1:0] ld, input logic [CH-1:0] md,
                           input int d0, input int d1, input int d2, input int d3);
        en   = '1;
        mode = md;
        load = ld;
        divisor = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        load = '0;
    endtask

    task automatic test_reset();
        en   = '1;
        mode = '0;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back('{0, k, steady(k, 1, 1'b0, 1'b1, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL reset_prerun ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
        #3 reset_n = 1'b0;
        for (int c = 0; c < CH; c++) exp_q.push_back('{c, 0, {1'b1, 1'b0, 1'b0, 32'd0}});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (observe(e.ch) !== e.v) begin
                failures++;
                $display("FAIL reset_async ch%0d got=%h exp=%h", e.ch, observe(e.ch), e.v);
            end
        end
        cyc();
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back('{0, k, steady(k, 1, 1'b0, 1'b1, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL reset_div ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
    endtask

    task automatic test_toggle();
        do_sync(4'b0001, 4'b0000, 3, 1, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back('{0, k, steady(k, 3, 1'b0, 1'b1, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL toggle ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
    endtask

    task automatic test_pulse();
        do_sync(4'b0010, 4'b0010, 1, 4, 1, 1);
        for (int k = 1; k <= 15; k++) begin
            exp_q.push_back('{1, k, steady(k, 4, 1'b1, 1'b1, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL pulse ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
    endtask

    task automatic test_reload();
        do_sync(4'b0001, 4'b0000, 9, 1, 1, 1);
        for (int k = 1; k <= 22; k++) begin
            load = '0;
            if (k == 6) begin
                load[0] = 1'b1;
                divisor[0 +: W] = 32'd7;
            end
            if (k == 8) begin
                load[0] = 1'b1;
                divisor[0 +: W] = 32'd2;
            end
            if (k <= 10) exp_q.push_back('{0, k, steady(k, 9, 1'b0, 1'b1, (k >= 6 && k <= 9))});
            else         exp_q.push_back('{0, k, steady(k - 10, 2, 1'b0, 1'b0, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL reload ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
        load = '0;
    endtask

    task automatic test_div_zero();
        do_sync(4'b0100, 4'b0000, 1, 1, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            load = '0;
            if (k == 7) begin
                load[2] = 1'b1;
                divisor[2*W +: W] = 32'd3;
            end
            if (k < 7) exp_q.push_back('{2, k, steady(k, 0, 1'b0, 1'b1, 1'b0)});
            else       exp_q.push_back('{2, k, steady(k - 7, 3, 1'b0, 1'b0, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL div_zero ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
        load = '0;
    endtask

    task automatic test_enable();
        do_sync(4'b1000, 4'b0000, 1, 1, 1, 4);
        for (int k = 1; k <= 24; k++) begin
            load = '0;
            en[3] = !(k >= 3 && k <= 12);
            if (k == 7) begin
                load[3] = 1'b1;
                divisor[3*W +: W] = 32'd6;
            end
            if (k <= 2)       exp_q.push_back('{3, k, steady(k, 4, 1'b0, 1'b1, 1'b0)});
            else if (k <= 12) exp_q.push_back('{3, k, {1'b1, 1'b0, 1'b0, 32'd2}});
            else              exp_q.push_back('{3, k, steady(k - 10, 6, 1'b0, 1'b1, 1'b0)});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL enable ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
        load = '0;
        en   = '1;
    endtask

    task automatic test_sync();
        do_sync(4'b1111, 4'b0000, 3, 4, 5, 6);
        for (int k = 1; k <= 6; k++) begin
            load = '0;
            if (k == 6) begin
                load[0] = 1'b1;
                divisor[0 +: W] = 32'd2;
            end
            for (int c = 0; c < CH; c++)
                exp_q.push_back('{c, k, steady(k, 3 + c, 1'b0, 1'b1, (c == 0 && k == 6))});
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL sync_pre ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
        end
        divisor = {32'd2, 32'd2, 32'd2, 32'd9};
        load    = 4'b1110;
        sync    = 1'b1;
        for (int c = 0; c < CH; c++) exp_q.push_back('{c, 0, {1'b1, 1'b0, 1'b0, 32'd0}});
        cyc();
        sync = 1'b0;
        load = '0;
        for (int k = 1; k <= 10; k++) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe(e.ch) !== e.v) begin
                    failures++;
                    $display("FAIL sync_align ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
                end
            end
            for (int c = 0; c < CH; c++)
                exp_q.push_back('{c, k, steady(k, 2, 1'b0, 1'b1, 1'b0)});
            cyc();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (observe(e.ch) !== e.v) begin
                failures++;
                $display("FAIL sync_align ch%0d k=%0d got=%h exp=%h", e.ch, e.k, observe(e.ch), e.v);
            end
        end
    endtask

    initial begin
        en = '1;
        repeat (2) cyc();
        reset_n = 1'b1;
        test_reset();
        test_toggle();
        test_pulse();
        test_reload();
        test_div_zero();
        test_enable();
        test_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
